// File: rtl/sort_pkg.sv
// Shared sizing constants and FSM state encoding for the sort sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sort_pkg;
   localparam int DATA_W = 5;   // element width, unsigned
   localparam int DEPTH  = 16;  // number of elements, >= 2
   localparam int ADDR_W = 4;   // $clog2(DEPTH)
   localparam int SWAP_W = 7;   // holds DEPTH*(DEPTH-1)/2

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SORT   = 2'd1,
      FINISH = 2'd2
   } state_t;
endpackage

// File: rtl/sort_sequencer_if.sv
// Host-side bus of the sort sequencer: array load/read, start, status.
// Latency: n/a (wires only); read data arrives one cycle after rd_addr.
// Backpressure: none; writes while busy are dropped and flagged by wr_err.
interface sort_sequencer_if;
   import sort_pkg::*;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              start;
   logic              busy;
   logic              done;
   logic              wr_err;
   logic [SWAP_W-1:0] swap_cnt;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, start,
      input  rd_data, busy, done, wr_err, swap_cnt
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, start,
      output rd_data, busy, done, wr_err, swap_cnt
   );
endinterface

// File: rtl/sort_cmp_swap.sv
// Compare two unsigned elements and return them in ascending order.
// Latency: combinational.
// Backpressure: none; equal inputs are never reported as swapped.
module sort_cmp_swap
   import sort_pkg::*;
(
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_lo,
   output logic [DATA_W-1:0] o_hi,
   output logic              o_swapped
);
   logic w_gt;

   assign w_gt      = (i_a > i_b);
   assign o_swapped = w_gt;
   assign o_lo      = w_gt ? i_b : i_a;
   assign o_hi      = w_gt ? i_a : i_b;
endmodule

// File: rtl/sort_sequencer.sv
// In-place ascending bubble sort over a DEPTH-entry register array, one compare per clock.
// Latency: start -> done = compares+1 cycles (16 for sorted input, 121 fully reversed); rd_data 1 cycle.
// Backpressure: none; start ignored unless idle, writes outside IDLE dropped with a wr_err pulse.
module sort_sequencer
   import sort_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   sort_sequencer_if.slave  bus
);
   localparam logic [ADDR_W-1:0] LAST_J0 = ADDR_W'(DEPTH - 2);

   logic [DATA_W-1:0] r_mem [DEPTH];
   state_t            r_state;
   logic [ADDR_W-1:0] r_pass;
   logic [ADDR_W-1:0] r_j;
   logic              r_pass_swapped;
   logic              r_busy;
   logic              r_done;
   logic              r_wr_err;
   logic [SWAP_W-1:0] r_swap_cnt;
   logic [DATA_W-1:0] r_rd_data;

   logic [ADDR_W-1:0] w_j1;
   logic [ADDR_W-1:0] w_last_j;
   logic              w_end_pass;
   logic              w_any_swap;
   logic [DATA_W-1:0] w_lo;
   logic [DATA_W-1:0] w_hi;
   logic              w_swapped;

   assign w_j1       = r_j + ADDR_W'(1);
   assign w_last_j   = LAST_J0 - r_pass;   // each pass settles one more element at the top
   assign w_end_pass = (r_j == w_last_j);
   assign w_any_swap = r_pass_swapped | w_swapped;

   sort_cmp_swap u_cmp (
      .i_a       (r_mem[r_j]),
      .i_b       (r_mem[w_j1]),
      .o_lo      (w_lo),
      .o_hi      (w_hi),
      .o_swapped (w_swapped)
   );

   // Array storage: host writes only when idle, the sort swaps neighbours in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (r_state == IDLE && bus.wr_en) begin
         r_mem[bus.wr_addr] <= bus.wr_data;
      end else if (r_state == SORT && w_swapped) begin
         r_mem[r_j]  <= w_lo;
         r_mem[w_j1] <= w_hi;
      end
   end

   // Registered read port, live during the sort so intermediate states are visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rd_data <= '0;
      else        r_rd_data <= r_mem[bus.rd_addr];
   end

   // Sort control: pass/index counters, swap count and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_pass         <= '0;
         r_j            <= '0;
         r_pass_swapped <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_wr_err       <= 1'b0;
         r_swap_cnt     <= '0;
      end else begin
         r_done   <= 1'b0;
         r_wr_err <= bus.wr_en && (r_state != IDLE);
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_state        <= SORT;
                  r_pass         <= '0;
                  r_j            <= '0;
                  r_pass_swapped <= 1'b0;
                  r_swap_cnt     <= '0;
                  r_busy         <= 1'b1;
               end
            end
            SORT: begin
               if (w_swapped) r_swap_cnt <= r_swap_cnt + SWAP_W'(1);
               if (w_end_pass) begin
                  // A clean pass means the array is ordered; the last pass is forced final.
                  if (!w_any_swap || r_pass == LAST_J0) begin
                     r_state <= FINISH;
                     r_busy  <= 1'b0;
                  end else begin
                     r_pass         <= r_pass + ADDR_W'(1);
                     r_j            <= '0;
                     r_pass_swapped <= 1'b0;
                  end
               end else begin
                  r_j            <= w_j1;
                  r_pass_swapped <= w_any_swap;
               end
            end
            FINISH: begin
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.rd_data  = r_rd_data;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.wr_err   = r_wr_err;
   assign bus.swap_cnt = r_swap_cnt;
endmodule

// File: tb/tb_sort_sequencer.sv
// Self-checking bench for sort_sequencer with a reference bubble-sort model and read scoreboard.
// Latency: checks start->done timing, busy length and 1-cycle read latency.
// Backpressure: exercises dropped writes and ignored starts while busy.
module tb_sort_sequencer;
   import sort_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sort_sequencer_if bus ();

   sort_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int n_done = 0;

   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W-1:0] exp_q [$];

   // Count done pulses away from the active edge.
   always @(negedge clk) if (bus.done === 1'b1) n_done++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input int a, input int d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = ADDR_W'(a);
      bus.wr_data = DATA_W'(d);
      tick();
      bus.wr_en   = 1'b0;
      ref_mem[a]  = DATA_W'(d);
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         bus.rd_addr = ADDR_W'(i);
         exp_q.push_back(ref_mem[i]);
         tick();
         chk(tag, bus.rd_data, exp_q.pop_front());
      end
   endtask

   // Reference: ascending bubble sort with early exit, counting compares and swaps.
   task automatic model_sort(output int cmps, output int swps);
      logic [DATA_W-1:0] t;
      bit sw;
      cmps = 0;
      swps = 0;
      for (int p = 0; p <= DEPTH - 2; p++) begin
         sw = 1'b0;
         for (int j = 0; j <= DEPTH - 2 - p; j++) begin
            cmps++;
            if (ref_mem[j] > ref_mem[j+1]) begin
               t            = ref_mem[j];
               ref_mem[j]   = ref_mem[j+1];
               ref_mem[j+1] = t;
               swps++;
               sw = 1'b1;
            end
         end
         if (!sw) break;
      end
   endtask

   task automatic run_sort(input bit inj, input bit wr0, input int exp_cmp, input int exp_swp);
      int d0, busy_n, done_at;
      d0      = n_done;
      busy_n  = 0;
      done_at = -1;
      bus.start = 1'b1;
      if (wr0) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = '0;
         bus.wr_data = DATA_W'(31);
      end
      tick();
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      for (int o = 0; o < 400 && done_at < 0; o++) begin
         if (bus.busy === 1'b1) busy_n++;
         if (bus.done === 1'b1) done_at = o;
         if (inj && o == 2) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = ADDR_W'(5);
            bus.wr_data = DATA_W'(31);
            bus.start   = 1'b1;
         end
         if (inj && o == 3) begin
            chk("wr_err_pulse", bus.wr_err, 1);
            bus.wr_en = 1'b0;
            bus.start = 1'b0;
         end
         if (inj && o == 4) chk("wr_err_clear", bus.wr_err, 0);
         if (done_at < 0) tick();
      end
      chk("busy_cycles", busy_n, exp_cmp);
      chk("done_offset", done_at, exp_cmp + 1);
      chk("swap_cnt", bus.swap_cnt, exp_swp);
      repeat (3) tick();
      chk("done_pulses", n_done - d0, 1);
      chk("idle_busy", bus.busy, 0);
      chk("swap_hold", bus.swap_cnt, exp_swp);
   endtask

   initial begin
      int c, s, d0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_addr = '0;
      bus.start   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Reset state
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_wr_err", bus.wr_err, 0);
      chk("rst_swap", bus.swap_cnt, 0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      read_all("rst_rd");

      // Fully reversed
      for (int i = 0; i < DEPTH; i++) write(i, DEPTH - 1 - i);
      model_sort(c, s);
      run_sort(1'b0, 1'b0, c, s);
      read_all("rev_rd");

      // Already ascending
      for (int i = 0; i < DEPTH; i++) write(i, i);
      model_sort(c, s);
      run_sort(1'b0, 1'b0, c, s);
      read_all("asc_rd");

      // Duplicates, dropped write and ignored start while busy
      write(0, 3);
      write(1, 3);
      write(2, 1);
      for (int i = 3; i < DEPTH; i++) write(i, 0);
      model_sort(c, s);
      run_sort(1'b1, 1'b0, c, s);
      read_all("dup_rd");

      // Reset in the middle of a sort
      for (int i = 0; i < DEPTH; i++) write(i, DEPTH - 1 - i);
      d0 = n_done;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (39) tick();
      rst_n = 1'b0;
      tick();
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_swap", bus.swap_cnt, 0);
      chk("mid_rst_rd", bus.rd_data, 0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("mid_rst_no_done", n_done - d0, 0);
      chk("mid_rst_idle", bus.busy, 0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      read_all("mid_rst_rd");

      // Write and start on the same edge
      ref_mem[0] = DATA_W'(31);
      model_sort(c, s);
      run_sort(1'b0, 1'b1, c, s);
      read_all("wr_start_rd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
